decodificador_obstaculos: RTL and testbench

Consumer side of the obstacle-ROM interface. Takes the 7-segment pattern (abcdefg) currently reaching the hero's column and decodes it back to its obstacle/bonus index. It checks overlap against the hero's own segment mask and keeps the game's score, lives and game-over state. It sits between the scrolling display pipeline and the score/lives display drivers.

---
 rtl/decodificador_obstaculos.sv | 132 +++++++++++++
 tb/tb_decodificador_obstaculos.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_obstaculos.sv
// Decodes the 7-seg pattern at the hero column to an obstacle/bonus index; tracks score, lives, game over.
// Latency: one register stage (strobe at edge N -> results at N+1). No backpressure: accepts a strobe every cycle.
module decodificador_obstaculos #(
    parameter int VIDAS_INI  = 3,
    parameter int INVULN_CYC = 8,
    parameter int SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               seg_valid,
    input  logic [6:0]         seg,
    input  logic [6:0]         hero_seg,
    output logic               out_valid,
    output logic [3:0]         idx,
    output logic               es_bonus,
    output logic               choque,
    output logic [SCORE_W-1:0] puntos,
    output logic [1:0]         vidas,
    output logic               game_over
);
    typedef enum logic [1:0] {JUGANDO, INVULNERABLE, FIN} estado_t;

    localparam int CNT_W = $clog2(INVULN_CYC + 1);

    estado_t            estado;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         idx_dec;
    logic               contacto;
    logic               es_obst;
    logic               es_bon;
    logic               golpe;
    logic [SCORE_W:0]   inc;
    logic [SCORE_W:0]   suma;
    logic [SCORE_W-1:0] puntos_sat;

    always_comb begin
        case (seg)
            7'b0001111: idx_dec = 4'd0;
            7'b1100011: idx_dec = 4'd1;
            7'b0111000: idx_dec = 4'd2;
            7'b0010011: idx_dec = 4'd3;
            7'b1000001: idx_dec = 4'd4;
            7'b0111111: idx_dec = 4'd5;
            7'b0110110: idx_dec = 4'd6;
            7'b0010101: idx_dec = 4'd7;
            7'b0110001: idx_dec = 4'd8;
            7'b1111110: idx_dec = 4'd9;
            7'b0110000: idx_dec = 4'd10;
            7'b1101101: idx_dec = 4'd11;
            7'b1111001: idx_dec = 4'd12;
            default:    idx_dec = 4'hF;
        endcase
    end

    assign contacto = |(seg & hero_seg);
    assign es_obst  = (idx_dec <= 4'd9);
    assign es_bon   = (idx_dec >= 4'd10) && (idx_dec <= 4'd12);
    assign golpe    = seg_valid && (estado == JUGANDO) && es_obst && contacto;

    always_comb begin
        inc = '0;
        if (es_obst && !contacto) begin
            inc = (SCORE_W+1)'(1);
        end else if (es_bon && contacto) begin
            case (idx_dec)
                4'd10:   inc = (SCORE_W+1)'(10);
                4'd11:   inc = (SCORE_W+1)'(20);
                default: inc = (SCORE_W+1)'(30);
            endcase
        end
    end

    // One extra bit catches the carry; clamp instead of wrapping.
    assign suma       = {1'b0, puntos} + inc;
    assign puntos_sat = suma[SCORE_W] ? {SCORE_W{1'b1}} : suma[SCORE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= JUGANDO;
            cnt       <= '0;
            out_valid <= 1'b0;
            idx       <= 4'hF;
            es_bonus  <= 1'b0;
            choque    <= 1'b0;
            puntos    <= '0;
            vidas     <= 2'(VIDAS_INI);
            game_over <= 1'b0;
        end else if (clear) begin
            estado    <= JUGANDO;
            cnt       <= '0;
            out_valid <= 1'b0;
            idx       <= 4'hF;
            es_bonus  <= 1'b0;
            choque    <= 1'b0;
            puntos    <= '0;
            vidas     <= 2'(VIDAS_INI);
            game_over <= 1'b0;
        end else begin
            out_valid <= seg_valid;
            es_bonus  <= 1'b0;
            choque    <= 1'b0;
            if (seg_valid) begin
                idx <= idx_dec;
                if (estado != FIN) begin
                    puntos   <= puntos_sat;
                    es_bonus <= es_bon && contacto;
                end
            end
            if (golpe) begin
                choque <= 1'b1;
                vidas  <= vidas - 2'd1;
                if (vidas == 2'd1) begin
                    estado    <= FIN;
                    game_over <= 1'b1;
                    cnt       <= '0;
                end else begin
                    estado <= INVULNERABLE;
                    cnt    <= CNT_W'(INVULN_CYC);
                end
            end else if (estado == INVULNERABLE) begin
                // Leaving on the count of 1 makes the immunity window exactly INVULN_CYC strobe slots.
                if (cnt <= CNT_W'(1)) begin
                    estado <= JUGANDO;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_decodificador_obstaculos.sv
// Scoreboard bench for decodificador_obstaculos with directed, hand-computed vectors.
module tb_decodificador_obstaculos;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       seg_valid;
    logic [6:0] seg;
    logic [6:0] hero_seg;
    logic       out_valid;
    logic [3:0] idx;
    logic       es_bonus;
    logic       choque;
    logic [9:0] puntos;
    logic [1:0] vidas;
    logic       game_over;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic       bon;
        logic       cho;
        logic [9:0] pts;
        logic [1:0] vid;
        logic       go;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic [6:0] pats    [15];
    logic [3:0] pat_idx [15];

    decodificador_obstaculos #(.VIDAS_INI(3), .INVULN_CYC(8), .SCORE_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .seg_valid(seg_valid), .seg(seg),
        .hero_seg(hero_seg), .out_valid(out_valid), .idx(idx), .es_bonus(es_bonus),
        .choque(choque), .puntos(puntos), .vidas(vidas), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_idx"},       32'(idx), 15);
        check({tag, "_es_bonus"},  32'(es_bonus), 0);
        check({tag, "_choque"},    32'(choque), 0);
        check({tag, "_puntos"},    32'(puntos), 0);
        check({tag, "_vidas"},     32'(vidas), 3);
        check({tag, "_game_over"}, 32'(game_over), 0);
    endtask

    task automatic send(input logic [6:0] s, input logic [6:0] h, input logic [3:0] ei,
                        input logic eb, input logic ec, input logic [9:0] ep,
                        input logic [1:0] ev, input logic eg);
        exp_t e;
        e = '{idx: ei, bon: eb, cho: ec, pts: ep, vid: ev, go: eg};
        q.push_back(e);
        seg       = s;
        hero_seg  = h;
        seg_valid = 1'b1;
        @(posedge clk);
        #1 seg_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    // Monitor: pops one expectation per out_valid pulse; pulses must be quiet otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected none pending (t=%0t)", $time);
                end else begin
                    mon_e = q.pop_front();
                    check("idx",       32'(idx),       32'(mon_e.idx));
                    check("es_bonus",  32'(es_bonus),  32'(mon_e.bon));
                    check("choque",    32'(choque),    32'(mon_e.cho));
                    check("puntos",    32'(puntos),    32'(mon_e.pts));
                    check("vidas",     32'(vidas),     32'(mon_e.vid));
                    check("game_over", 32'(game_over), 32'(mon_e.go));
                end
            end else begin
                check("idle_pulses", 32'({es_bonus, choque}), 0);
            end
        end
    end

    initial begin
        pats = '{7'b0001111, 7'b1100011, 7'b0111000, 7'b0010011, 7'b1000001,
                 7'b0111111, 7'b0110110, 7'b0010101, 7'b0110001, 7'b1111110,
                 7'b0110000, 7'b1101101, 7'b1111001, 7'b0000000, 7'b1010101};
        pat_idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                    4'd10, 4'd11, 4'd12, 4'd15, 4'd15};

        rst = 1'b1; clear = 1'b0; seg_valid = 1'b0; seg = '0; hero_seg = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        rst = 1'b0;
        idle(1);

        // Table walk with no contact: only the ten obstacles score.
        for (int i = 0; i < 15; i++) begin
            send(pats[i], 7'b0000000, pat_idx[i], 1'b0, 1'b0,
                 (i <= 9) ? 10'(i + 1) : 10'd10, 2'd3, 1'b0);
        end
        idle(2);

        // Bonuses.
        do_clear();
        send(7'b1111001, 7'b0000001, 4'd12, 1'b1, 1'b0, 10'd30, 2'd3, 1'b0);
        send(7'b0110000, 7'b0110001, 4'd10, 1'b1, 1'b0, 10'd40, 2'd3, 1'b0);
        send(7'b1101101, 7'b0000100, 4'd11, 1'b1, 1'b0, 10'd60, 2'd3, 1'b0);
        send(7'b0110000, 7'b0000001, 4'd10, 1'b0, 1'b0, 10'd60, 2'd3, 1'b0);
        idle(2);

        // Lives, immunity window, game over.
        do_clear();
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd0, 2'd2, 1'b0);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b0, 10'd0, 2'd2, 1'b0);
        idle(1);
        send(7'b0001111, 7'b1110000, 4'd0, 1'b0, 1'b0, 10'd1, 2'd2, 1'b0);
        idle(4);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b0, 10'd1, 2'd2, 1'b0);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd1, 2'd1, 1'b0);
        idle(20);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd1, 2'd0, 1'b1);
        idle(3);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b0, 10'd1, 2'd0, 1'b1);
        send(7'b0001111, 7'b0000000, 4'd0, 1'b0, 1'b0, 10'd1, 2'd0, 1'b1);
        idle(2);
        check("fin_game_over_level", 32'(game_over), 1);
        check("fin_vidas_level", 32'(vidas), 0);

        // Saturation at 1023.
        do_clear();
        for (int k = 1; k <= 36; k++) begin
            send(7'b1111001, 7'b0000001, 4'd12, 1'b1, 1'b0,
                 (k * 30 > 1023) ? 10'd1023 : 10'(k * 30), 2'd3, 1'b0);
        end
        idle(2);

        // clear beats a same-cycle contacting obstacle during immunity.
        do_clear();
        send(7'b0001111, 7'b0000000, 4'd0, 1'b0, 1'b0, 10'd1, 2'd3, 1'b0);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd1, 2'd2, 1'b0);
        clear = 1'b1; seg = 7'b0110110; hero_seg = 7'b0000110; seg_valid = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; seg_valid = 1'b0;
        check_reset_vals("clear");
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd0, 2'd2, 1'b0);

        // Asynchronous reset mid-immunity.
        idle(1);
        #3 rst = 1'b1;
        #1 check_reset_vals("rst_inv");
        #1 rst = 1'b0;
        idle(1);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd0, 2'd2, 1'b0);

        // Asynchronous reset mid-FIN.
        idle(9);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd0, 2'd1, 1'b0);
        idle(9);
        send(7'b0110110, 7'b0000110, 4'd6, 1'b0, 1'b1, 10'd0, 2'd0, 1'b1);
        idle(1);
        #3 rst = 1'b1;
        #1 check_reset_vals("rst_fin");
        #1 rst = 1'b0;
        idle(1);
        send(7'b0001111, 7'b0000000, 4'd0, 1'b0, 1'b0, 10'd1, 2'd3, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
